// File: rtl/gate_pkg.sv
// Shared definitions for the gate self-test sequencer.
// - state_e       : sequencer FSM states
// - GATE_*        : bit position of each gate in the 8-bit response vector
// - gate_expected : golden 8-bit response for a stimulus pair (a, b)
package gate_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StSample,
      StDone
   } state_e;

   localparam int unsigned GATE_BUF  = 0;
   localparam int unsigned GATE_NOT  = 1;
   localparam int unsigned GATE_AND  = 2;
   localparam int unsigned GATE_OR   = 3;
   localparam int unsigned GATE_NOR  = 4;
   localparam int unsigned GATE_NAND = 5;
   localparam int unsigned GATE_XOR  = 6;
   localparam int unsigned GATE_XNOR = 7;

   function automatic logic [7:0] gate_expected(input logic a, input logic b);
      logic [7:0] v;
      v            = '0;
      v[GATE_BUF]  = a;
      v[GATE_NOT]  = ~a;
      v[GATE_AND]  = a & b;
      v[GATE_OR]   = a | b;
      v[GATE_NOR]  = ~(a | b);
      v[GATE_NAND] = ~(a & b);
      v[GATE_XOR]  = a ^ b;
      v[GATE_XNOR] = ~(a ^ b);
      return v;
   endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// Control handshake between a host and the gate sweep sequencer.
// - start     : host -> sequencer, begin a sweep (only honoured when idle)
// - busy      : sweep in progress
// - done      : one-cycle end-of-sweep pulse
// - pass      : no mismatch in last sweep, valid with done, held until next start
// - fail_mask : sticky per-gate mismatch bits of the current sweep
// - case_idx  : stimulus case currently driven
interface gate_sweep_ctrl_if;

   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] fail_mask;
   logic [3:0] case_idx;

   modport master (
      output start,
      input  busy, done, pass, fail_mask, case_idx
   );

   modport slave (
      input  start,
      output busy, done, pass, fail_mask, case_idx
   );

endinterface

// File: rtl/gate_bank.sv
// Bank of the eight two-input library gates sharing one stimulus pair.
// - a_i    : stimulus to every gate's i1 (and the single input of Buf/Not)
// - b_i    : stimulus to every gate's i2
// - resp_o : gate outputs, bit order given by the GATE_* constants
module gate_bank
   import gate_pkg::*;
(
   input  logic       a_i,
   input  logic       b_i,
   output logic [7:0] resp_o
);

   assign resp_o[GATE_BUF]  = a_i;
   assign resp_o[GATE_NOT]  = ~a_i;
   assign resp_o[GATE_AND]  = a_i & b_i;
   assign resp_o[GATE_OR]   = a_i | b_i;
   assign resp_o[GATE_NOR]  = ~(a_i | b_i);
   assign resp_o[GATE_NAND] = ~(a_i & b_i);
   assign resp_o[GATE_XOR]  = a_i ^ b_i;
   assign resp_o[GATE_XNOR] = ~(a_i ^ b_i);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the two-input gate library. Drives each stimulus case
// (NCASES-1 down to 0) onto stim_a_o/stim_b_o, waits SETTLE_CYCLES, samples resp_i
// and accumulates mismatches against the golden table into a sticky fail mask.
// - clk_i, rst_i         : clock, synchronous active-high reset
// - ctrl                 : start/busy/done/pass/fail_mask/case_idx handshake
// - resp_i               : gate bank outputs
// - stim_a_o, stim_b_o   : registered stimulus pair to the gate bank
module gate_sweep_ctrl
   import gate_pkg::*;
#(
   parameter int unsigned         NCASES        = 4,
   parameter logic [2*NCASES-1:0] PATTERN       = 8'b00011011,
   parameter int unsigned         SETTLE_CYCLES = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   gate_sweep_ctrl_if.slave        ctrl,
   input  logic [7:0]              resp_i,
   output logic                    stim_a_o,
   output logic                    stim_b_o
);

   localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   state_e              state_q, state_d;
   logic [3:0]          case_idx_q, case_idx_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                stim_a_q, stim_a_d;
   logic                stim_b_q, stim_b_d;
   logic [7:0]          fail_mask_q, fail_mask_d;
   logic                pass_q, pass_d;
   logic [7:0]          sample_mask;
   logic [2*NCASES-1:0] pat_sh;

   // Case k occupies PATTERN[2k+1:2k]; shifting avoids an over-wide bit select.
   assign pat_sh      = PATTERN >> {case_idx_q, 1'b0};
   assign sample_mask = fail_mask_q | (resp_i ^ gate_expected(stim_a_q, stim_b_q));

   always_comb begin
      state_d     = state_q;
      case_idx_d  = case_idx_q;
      cnt_d       = cnt_q;
      stim_a_d    = stim_a_q;
      stim_b_d    = stim_b_q;
      fail_mask_d = fail_mask_q;
      pass_d      = pass_q;
      unique case (state_q)
         StIdle: begin
            if (ctrl.start) begin
               state_d     = StDrive;
               case_idx_d  = 4'(NCASES - 1);
               fail_mask_d = '0;
               pass_d      = 1'b0;
            end
         end
         StDrive: begin
            stim_a_d = pat_sh[1];
            stim_b_d = pat_sh[0];
            cnt_d    = CntW'(SETTLE_CYCLES - 1);
            state_d  = StSettle;
         end
         StSettle: begin
            if (cnt_q == '0) begin
               state_d = StSample;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StSample: begin
            fail_mask_d = sample_mask;
            if (case_idx_q == 4'd0) begin
               state_d = StDone;
               // Resolve pass here so it is already valid alongside done.
               pass_d  = (sample_mask == 8'h00);
            end else begin
               case_idx_d = case_idx_q - 4'd1;
               state_d    = StDrive;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         case_idx_q  <= '0;
         cnt_q       <= '0;
         stim_a_q    <= 1'b0;
         stim_b_q    <= 1'b0;
         fail_mask_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         case_idx_q  <= case_idx_d;
         cnt_q       <= cnt_d;
         stim_a_q    <= stim_a_d;
         stim_b_q    <= stim_b_d;
         fail_mask_q <= fail_mask_d;
         pass_q      <= pass_d;
      end
   end

   assign stim_a_o       = stim_a_q;
   assign stim_b_o       = stim_b_q;
   assign ctrl.case_idx  = case_idx_q;
   assign ctrl.fail_mask = fail_mask_q;
   assign ctrl.pass      = pass_q;
   assign ctrl.done      = (state_q == StDone);
   assign ctrl.busy      = (state_q == StDrive) || (state_q == StSettle) ||
                           (state_q == StSample);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl driving a gate_bank, with optional
// fault injection on the response path and a behavioural reference model.
module tb_gate_sweep_ctrl;

   localparam int unsigned NCASES   = 4;
   localparam logic [7:0]  PATTERN  = 8'b00011011;
   localparam int unsigned SETTLE   = 4;
   localparam int          PER_CASE = SETTLE + 2;
   localparam int          LATENCY  = NCASES * PER_CASE;

   logic       clk = 1'b0;
   logic       rst;
   logic       stim_a, stim_b;
   logic [7:0] bank_resp, resp, noise;
   logic [7:0] flip_lut [4];
   logic       force_and, stuck_xnor;
   logic       chk_a, chk_b;
   logic [7:0] chk_resp;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   gate_sweep_ctrl_if ctrl_if ();

   gate_bank u_bank (
      .a_i    (stim_a),
      .b_i    (stim_b),
      .resp_o (bank_resp)
   );

   gate_bank u_bank_chk (
      .a_i    (chk_a),
      .b_i    (chk_b),
      .resp_o (chk_resp)
   );

   always_comb begin
      resp = bank_resp ^ flip_lut[{stim_a, stim_b}] ^ noise;
      if (force_and && !stim_a && stim_b) resp[2] = 1'b1;
      if (stuck_xnor) resp[7] = 1'b0;
   end

   gate_sweep_ctrl #(
      .NCASES        (NCASES),
      .PATTERN       (PATTERN),
      .SETTLE_CYCLES (SETTLE)
   ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .ctrl     (ctrl_if),
      .resp_i   (resp),
      .stim_a_o (stim_a),
      .stim_b_o (stim_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Golden truth table from plain arithmetic on 0/1 operands.
   function automatic logic [7:0] model_gold(input int a, input int b);
      logic [7:0] v;
      v[0] = (a == 1);
      v[1] = (1 - a == 1);
      v[2] = (a * b == 1);
      v[3] = (a + b > 0);
      v[4] = (a + b == 0);
      v[5] = (a * b == 0);
      v[6] = (a + b == 1);
      v[7] = (a + b != 1);
      return v;
   endfunction

   // Expected sticky mask: what a faulty bank would return, diffed against golden, over all cases.
   function automatic logic [7:0] model_mask();
      logic [7:0] m, pat, r, g;
      int a, b;
      m   = '0;
      pat = PATTERN;
      for (int k = 0; k < int'(NCASES); k++) begin
         a = int'(pat[2*k+1]);
         b = int'(pat[2*k]);
         g = model_gold(a, b);
         r = g ^ flip_lut[a*2+b];
         if (force_and && a == 0 && b == 1) r[2] = 1'b1;
         if (stuck_xnor) r[7] = 1'b0;
         m |= r ^ g;
      end
      return m;
   endfunction

   task automatic run_sweep(input string tag, input bit hold_start, input bit glitch,
                            input logic [7:0] exp_mask);
      int         c, k;
      logic [7:0] pat;
      pat = PATTERN;
      @(negedge clk);
      ctrl_if.start = 1'b1;
      @(negedge clk);
      check({tag, "/busy_at_start"}, ctrl_if.busy, 1);
      check({tag, "/idx_at_start"}, ctrl_if.case_idx, NCASES - 1);
      check({tag, "/mask_cleared"}, ctrl_if.fail_mask, 0);
      if (!hold_start) ctrl_if.start = 1'b0;
      c = 0;
      while (ctrl_if.done !== 1'b1 && c < 4 * LATENCY) begin
         // Garbage on resp everywhere except the cycle feeding the sampling edge.
         noise = (glitch && (c % PER_CASE) != PER_CASE - 1) ? 8'($urandom) : 8'h00;
         @(negedge clk);
         c++;
         if (ctrl_if.done !== 1'b1 && (c - 1) % PER_CASE == 2) begin
            k = int'(NCASES) - 1 - (c - 1) / PER_CASE;
            check({tag, "/stim_a"}, stim_a, pat[2*k+1]);
            check({tag, "/stim_b"}, stim_b, pat[2*k]);
            check({tag, "/case_idx"}, ctrl_if.case_idx, k);
            check({tag, "/busy_mid"}, ctrl_if.busy, 1);
         end
      end
      noise = 8'h00;
      check({tag, "/latency"}, c, LATENCY);
      check({tag, "/pass"}, ctrl_if.pass, (exp_mask == 8'h00));
      check({tag, "/fail_mask"}, ctrl_if.fail_mask, exp_mask);
      check({tag, "/busy_in_done"}, ctrl_if.busy, 0);
      check({tag, "/stim_hold"}, {stim_a, stim_b}, pat[1:0]);
      @(negedge clk);
      check({tag, "/done_pulse"}, ctrl_if.done, 0);
      check({tag, "/pass_held"}, ctrl_if.pass, (exp_mask == 8'h00));
      check({tag, "/mask_held"}, ctrl_if.fail_mask, exp_mask);
   endtask

   initial begin
      int c;
      bit seen;
      rst           = 1'b1;
      ctrl_if.start = 1'b0;
      noise         = 8'h00;
      force_and     = 1'b0;
      stuck_xnor    = 1'b0;
      chk_a         = 1'b0;
      chk_b         = 1'b0;
      for (int i = 0; i < 4; i++) flip_lut[i] = 8'h00;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst/busy", ctrl_if.busy, 0);
      check("rst/done", ctrl_if.done, 0);
      check("rst/pass", ctrl_if.pass, 0);
      check("rst/fail_mask", ctrl_if.fail_mask, 0);
      check("rst/case_idx", ctrl_if.case_idx, 0);
      check("rst/stim", {stim_a, stim_b}, 0);
      rst = 1'b0;

      // Gate bank against the arithmetic golden table
      for (int i = 0; i < 4; i++) begin
         chk_a = i[1];
         chk_b = i[0];
         #1;
         check("bank/truth", chk_resp, model_gold(i / 2, i % 2));
      end

      // Clean sweep
      run_sweep("clean", 1'b0, 1'b0, 8'h00);

      // AND forced high at (0,1)
      force_and = 1'b1;
      run_sweep("and_fault", 1'b0, 1'b0, 8'h04);
      force_and = 1'b0;

      // XNOR stuck at 0
      stuck_xnor = 1'b1;
      run_sweep("xnor_sa0", 1'b0, 1'b0, 8'h80);
      stuck_xnor = 1'b0;

      // start held through sweep and DONE: one sweep, restart only from IDLE
      run_sweep("hold", 1'b1, 1'b0, 8'h00);
      check("hold/idle_gap", ctrl_if.busy, 0);
      @(negedge clk);
      check("hold/restart", ctrl_if.busy, 1);
      ctrl_if.start = 1'b0;
      seen = 0;
      for (int i = 0; i < 2 * LATENCY && !seen; i++) begin
         @(negedge clk);
         if (ctrl_if.done === 1'b1) seen = 1;
      end
      check("hold/second_done", seen, 1);
      @(negedge clk);

      // Reset during SETTLE of case k=2
      ctrl_if.start = 1'b1;
      @(negedge clk);
      ctrl_if.start = 1'b0;
      repeat (PER_CASE + 3) @(negedge clk);
      check("midrst/case_idx_before", ctrl_if.case_idx, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst/busy", ctrl_if.busy, 0);
      check("midrst/done", ctrl_if.done, 0);
      check("midrst/case_idx", ctrl_if.case_idx, 0);
      check("midrst/stim", {stim_a, stim_b}, 0);
      check("midrst/fail_mask", ctrl_if.fail_mask, 0);
      seen = 0;
      for (int i = 0; i < 2 * LATENCY; i++) begin
         @(negedge clk);
         if (ctrl_if.done === 1'b1 || ctrl_if.busy === 1'b1) seen = 1;
      end
      check("midrst/stays_idle", seen, 0);
      run_sweep("after_rst", 1'b0, 1'b0, 8'h00);

      // Randomised faults, start hold and response glitches against the model
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < 4; i++)
            flip_lut[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
         run_sweep($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 1'b1, model_mask());
         ctrl_if.start = 1'b0;
         c = 0;
         while (ctrl_if.busy !== 1'b0 && c < 2 * LATENCY) begin
            @(negedge clk);
            c++;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
